// File: rtl/gates_vector_seq.sv
// Sweep sequencer for the 3-input gates block: steps vec through every combination,
// holds each for DWELL clocks and captures f_in into resp. Define GATES_SEQ_GRAY_EN for Gray order.
`timescale 1ns/1ps
module gates_vector_seq #(
  parameter int WIDTH = 3,
  parameter int DWELL = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                f_in,
  output logic [WIDTH-1:0]    vec,
  output logic                busy,
  output logic                done,
  output logic [2**WIDTH-1:0] resp
);

  localparam int                CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [WIDTH-1:0]  IDX_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_idx, w_idx_nxt;
  logic [WIDTH-1:0]     r_vec, w_vec_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [2**WIDTH-1:0]  r_resp, w_resp_nxt;

  function automatic logic [WIDTH-1:0] order(input logic [WIDTH-1:0] i);
`ifdef GATES_SEQ_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_resp  <= w_resp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_resp_nxt  = r_resp;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
          w_vec_nxt   = order('0);
          w_cnt_nxt   = CNT_LOAD;
          w_resp_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        // abort outranks the sample that would land on this edge
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_resp_nxt[r_vec] = f_in;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            w_vec_nxt = order(r_idx + 1'b1);
            w_cnt_nxt = CNT_LOAD;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign vec  = r_vec;
  assign busy = r_busy;
  assign done = r_done;
  assign resp = r_resp;

endmodule

// File: tb/tb_gates_vector_seq.sv
// Bench for gates_vector_seq: DWELL=4 and DWELL=1 instances, table of sweeps plus
// hand sequences for start/abort collision, mid-sweep reset and single-cycle dwell.
`timescale 1ns/1ps
module tb_gates_vector_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, abort4 = 1'b0, f_in4;
  logic [2:0] vec4;
  logic       busy4, done4;
  logic [7:0] resp4;
  logic       start1 = 1'b0, abort1 = 1'b0, f_in1;
  logic [2:0] vec1;
  logic       busy1, done1;
  logic [7:0] resp1;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  always #5 clk = ~clk;

  gates_vector_seq #(.WIDTH(3), .DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .f_in(f_in4),
    .vec(vec4), .busy(busy4), .done(done4), .resp(resp4)
  );

  gates_vector_seq #(.WIDTH(3), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f_in1),
    .vec(vec1), .busy(busy1), .done(done1), .resp(resp1)
  );

  always_comb begin
    case (mode)
      0:       f_in4 = 1'b0;
      1:       f_in4 = vec4[0];
      2:       f_in4 = vec4[2] & vec4[1];
      default: f_in4 = 1'b1;
    endcase
  end
  assign f_in1 = vec1[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_order(input int i);
    logic [2:0] b;
    b = 3'(i);
`ifdef GATES_SEQ_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  typedef struct {
    string      name;
    int         mode;
    int         abort_at;
    int         re_a;
    int         re_b;
    int         exp_busy;
    int         exp_done;
    logic [7:0] exp_resp;
  } sweep_t;

  sweep_t tbl[8];

  task automatic sweep4(input sweep_t t);
    int nb = 0, nd = 0, verr = 0, tail = 0;
    logic done_at_fall = 1'b0;
    mode = t.mode;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (busy4) begin
        nb++;
        if (vec4 !== exp_order((nb - 1) / 4)) verr++;
        start4 = (nb == t.re_a) || (nb == t.re_b);
        abort4 = (nb == t.abort_at);
      end else begin
        start4 = 1'b0;
        abort4 = 1'b0;
        if (done4) nd++;
        if (tail == 0) done_at_fall = done4;
        tail++;
        if (tail > 4) break;
      end
      @(negedge clk);
    end
    chk({t.name, "_busy_cycles"}, nb, t.exp_busy);
    chk({t.name, "_done_count"}, nd, t.exp_done);
    chk({t.name, "_done_timing"}, {31'b0, done_at_fall}, t.exp_done);
    chk({t.name, "_vec_seq_errs"}, verr, 0);
    chk({t.name, "_resp"}, {24'b0, resp4}, {24'b0, t.exp_resp});
  endtask

  initial begin
    int nb, verr;
    tbl[0] = '{"zero_f",       0,  0,  0,  0, 32, 1, 8'h00};
    tbl[1] = '{"f_c",          1,  0,  0,  0, 32, 1, 8'hAA};
    tbl[2] = '{"f_ab",         2,  0,  0,  0, 32, 1, 8'hC0};
    tbl[3] = '{"f_one",        3,  0,  0,  0, 32, 1, 8'hFF};
    tbl[4] = '{"abort10",      3, 10,  0,  0, 10, 0, 8'h03};
    tbl[5] = '{"abort_sample", 3, 12,  0,  0, 12, 0, 8'h03};
    tbl[6] = '{"abort_first",  3,  4,  0,  0,  4, 0, 8'h00};
    tbl[7] = '{"restart",      1,  0,  5, 31, 32, 1, 8'hAA};

    #1;
    chk("rst_vec",  {29'b0, vec4}, 0);
    chk("rst_busy", {31'b0, busy4}, 0);
    chk("rst_done", {31'b0, done4}, 0);
    chk("rst_resp", {24'b0, resp4}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) sweep4(tbl[i]);

    // start and abort together while idle: stay idle
    @(negedge clk); start4 = 1'b1; abort4 = 1'b1;
    @(negedge clk); start4 = 1'b0; abort4 = 1'b0;
    chk("start_abort_idle_busy", {31'b0, busy4}, 0);
    @(negedge clk);
    chk("start_abort_idle_busy2", {31'b0, busy4}, 0);

    // reset mid-sweep at busy cycle 17
    mode = 3;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    nb = 0;
    for (int c = 0; c < 40 && nb < 17; c++) begin
      if (busy4) nb++;
      if (nb < 17) @(negedge clk);
    end
    chk("midreset_reached17", nb, 17);
    chk("midreset_resp_before", {24'b0, resp4}, 32'h0F);
    rst_n = 1'b0;
    #1;
    chk("midreset_vec",  {29'b0, vec4}, 0);
    chk("midreset_busy", {31'b0, busy4}, 0);
    chk("midreset_resp", {24'b0, resp4}, 0);
    @(negedge clk); rst_n = 1'b1;
    sweep4('{"after_reset", 1, 0, 0, 0, 32, 1, 8'hAA});

    // DWELL=1 instance: new vector every clock
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    nb = 0; verr = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy1) begin
        if (vec1 !== exp_order(nb)) verr++;
        nb++;
      end else if (nb > 0) begin
        break;
      end
      @(negedge clk);
    end
    chk("dwell1_busy_cycles", nb, 8);
    chk("dwell1_vec_seq_errs", verr, 0);
    chk("dwell1_done", {31'b0, done1}, 1);
    chk("dwell1_resp", {24'b0, resp1}, 32'hAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
